// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, complex sample type and bit-reversal helper.
package fft_pkg;

    localparam int unsigned DATA_W = 19;
    localparam int unsigned N      = 32;
    localparam int unsigned LOG2N  = 5;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: 32-entry register file, single write port, asynchronous read port.
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * DATA_W
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [LOG2N-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [LOG2N-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_output_reorder.sv
// Converts a bit-reversed FFT output stream into natural bin order using two ping-pong banks.
// Define FFT_REORDER_INDEX_EN to add the index_o bin-number output.
module fft_output_reorder #(
    parameter int unsigned DATA_W = fft_pkg::DATA_W,
    parameter int unsigned N      = fft_pkg::N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_in_r,
    input  logic [DATA_W-1:0] data_in_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_out_r,
    output logic [DATA_W-1:0] data_out_i
`ifdef FFT_REORDER_INDEX_EN
    ,
    output logic [fft_pkg::LOG2N-1:0] index_o
`endif
);

    import fft_pkg::*;

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [LOG2N-1:0]    r_wr_cnt;
    logic [LOG2N-1:0]    r_rd_cnt;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic                r_armed;

    logic                w_frame_done;
    logic [LOG2N-1:0]    w_waddr;
    logic [2*DATA_W-1:0] w_wdata;
    logic [2*DATA_W-1:0] w_rdata0;
    logic [2*DATA_W-1:0] w_rdata1;
    logic [2*DATA_W-1:0] w_rdata;
    logic                w_we0;
    logic                w_we1;

    assign w_frame_done = valid_i && (r_wr_cnt == LAST);
    assign w_waddr      = bitrev5(r_wr_cnt);
    assign w_wdata      = {data_in_r, data_in_i};
    assign w_we0        = valid_i && !r_wr_bank;
    assign w_we1        = valid_i && r_wr_bank;
    assign w_rdata      = r_rd_bank ? w_rdata1 : w_rdata0;

    fft_reorder_bank #(
        .WIDTH(2 * DATA_W)
    ) u_bank0 (
        .clk    (clk),
        .i_we   (w_we0),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata),
        .i_raddr(r_rd_cnt),
        .o_rdata(w_rdata0)
    );

    fft_reorder_bank #(
        .WIDTH(2 * DATA_W)
    ) u_bank1 (
        .clk    (clk),
        .i_we   (w_we1),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata),
        .i_raddr(r_rd_cnt),
        .o_rdata(w_rdata1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_armed    <= 1'b0;
            valid_o    <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
`ifdef FFT_REORDER_INDEX_EN
            index_o    <= '0;
`endif
        end else begin
            if (valid_i) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_frame_done) begin
                r_wr_bank <= ~r_wr_bank;
            end

            if (r_armed) begin
                valid_o    <= 1'b1;
                data_out_r <= w_rdata[2*DATA_W-1:DATA_W];
                data_out_i <= w_rdata[DATA_W-1:0];
`ifdef FFT_REORDER_INDEX_EN
                index_o    <= r_rd_cnt;
`endif
                r_rd_cnt   <= r_rd_cnt + 1'b1;
                if (r_rd_cnt == LAST) begin
                    r_armed <= 1'b0;
                end
            end else begin
                valid_o    <= 1'b0;
                data_out_r <= '0;
                data_out_i <= '0;
`ifdef FFT_REORDER_INDEX_EN
                index_o    <= '0;
`endif
            end

            // A frame finishing on the last readout edge re-arms so output stays gap-free.
            if (w_frame_done) begin
                r_armed   <= 1'b1;
                r_rd_cnt  <= '0;
                r_rd_bank <= r_wr_bank;
            end
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Self-checking bench for fft_output_reorder: directed tables plus a frame-level reference model.
module tb_fft_output_reorder;

    localparam int DW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [DW-1:0] data_in_r;
    logic [DW-1:0] data_in_i;
    logic          valid_o;
    logic [DW-1:0] data_out_r;
    logic [DW-1:0] data_out_i;
`ifdef FFT_REORDER_INDEX_EN
    logic [4:0]    index_o;
`endif

    always #5 clk = ~clk;

    fft_output_reorder #(
        .DATA_W(DW),
        .N     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .data_in_r (data_in_r),
        .data_in_i (data_in_i),
        .valid_o   (valid_o),
        .data_out_r(data_out_r),
        .data_out_i(data_out_i)
`ifdef FFT_REORDER_INDEX_EN
        ,
        .index_o   (index_o)
`endif
    );

    typedef struct {
        int unsigned   edge_no;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [4:0]    idx;
    } exp_t;

    typedef struct {
        logic [DW-1:0] in_r;
        logic [DW-1:0] in_i;
        logic [DW-1:0] exp_r;
        logic [DW-1:0] exp_i;
    } vec_t;

    int unsigned   n_chk = 0;
    int unsigned   n_pass = 0;
    int unsigned   edge_cnt = 0;
    exp_t          q[$];
    logic [DW-1:0] fr_re[32];
    logic [DW-1:0] fr_im[32];
    int            fill = 0;
    vec_t          tbl[32];

    function automatic int rev5(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < 5; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_cnt);
    endtask

    // Drive one cycle, update the frame model at the edge, then compare outputs 1ns later.
    task automatic step(input logic r, input logic v, input logic [DW-1:0] re,
                        input logic [DW-1:0] im);
        exp_t        e;
        logic [4:0]  idx_act;
        logic [4:0]  idx_exp;
        logic [63:0] expv;
        rst       = r;
        valid_i   = v;
        data_in_r = re;
        data_in_i = im;
        @(posedge clk);
        edge_cnt++;
        if (r) begin
            q.delete();
            fill = 0;
        end else if (v) begin
            fr_re[fill] = re;
            fr_im[fill] = im;
            fill++;
            if (fill == 32) begin
                for (int k = 0; k < 32; k++) begin
                    e.edge_no = edge_cnt + 1 + k;
                    e.re      = fr_re[rev5(k)];
                    e.im      = fr_im[rev5(k)];
                    e.idx     = 5'(k);
                    q.push_back(e);
                end
                fill = 0;
            end
        end
        #1;
`ifdef FFT_REORDER_INDEX_EN
        idx_act = index_o;
`else
        idx_act = 5'd0;
`endif
        expv = 64'd0;
        if (q.size() > 0 && q[0].edge_no == edge_cnt) begin
            e = q.pop_front();
`ifdef FFT_REORDER_INDEX_EN
            idx_exp = e.idx;
`else
            idx_exp = 5'd0;
`endif
            expv = 64'({1'b1, e.re, e.im, idx_exp});
        end
        check("model_out", 64'({valid_o, data_out_r, data_out_i, idx_act}), expv);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, DW'($urandom), DW'($urandom));
    endtask

    task automatic table_frame();
        for (int n = 0; n < 32; n++) step(1'b0, 1'b1, tbl[n].in_r, tbl[n].in_i);
        for (int k = 0; k < 32; k++) begin
            step(1'b0, 1'b0, '0, '0);
            check("tbl_valid", 64'(valid_o), 64'd1);
            check("tbl_re", 64'(data_out_r), 64'(tbl[k].exp_r));
            check("tbl_im", 64'(data_out_i), 64'(tbl[k].exp_i));
`ifdef FFT_REORDER_INDEX_EN
            check("tbl_index", 64'(index_o), 64'(k));
`endif
        end
        step(1'b0, 1'b0, '0, '0);
        check("tbl_end_valid", 64'(valid_o), 64'd0);
    endtask

    initial begin
        int vc;
        int first;
        int last;
        int oc;
        int smp;

        for (int n = 0; n < 32; n++) begin
            tbl[n].in_r  = DW'(n);
            tbl[n].in_i  = DW'(-n);
            tbl[n].exp_r = DW'(rev5(n));
            tbl[n].exp_i = DW'(-rev5(n));
        end

        // Reset with random activity on the inputs.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), DW'($urandom), DW'($urandom));
            check("rst_valid", 64'(valid_o), 64'd0);
            check("rst_data", 64'({data_out_r, data_out_i}), 64'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, DW'($urandom), DW'($urandom));
            check("post_rst_valid", 64'(valid_o), 64'd0);
        end

        table_frame();
        idle(3);

        // Back-to-back frames: 64 contiguous output cycles.
        vc = 0; first = -1; last = -1; oc = 0;
        for (int i = 0; i < 104; i++) begin
            if (i < 64) step(1'b0, 1'b1, DW'(i), DW'($urandom));
            else step(1'b0, 1'b0, '0, '0);
            if (valid_o) begin
                if (first < 0) first = i;
                last = i;
                vc++;
                if (oc >= 32) check("b2b_second_re", 64'(data_out_r), 64'(32 + rev5(oc - 32)));
                oc++;
            end
        end
        check("b2b_count", 64'(vc), 64'd64);
        check("b2b_contig", 64'(last - first + 1), 64'd64);
        check("b2b_latency", 64'(first), 64'd32);

        // Gapped input: valid toggles every cycle.
        vc = 0; first = -1; last = -1; smp = 0;
        for (int i = 0; i < 110; i++) begin
            if (i < 64 && i % 2 == 0) begin
                step(1'b0, 1'b1, DW'(smp), DW'(-smp));
                smp++;
            end else begin
                step(1'b0, 1'b0, DW'($urandom), DW'($urandom));
            end
            if (valid_o) begin
                if (first < 0) first = i;
                check("gap_re", 64'(data_out_r), 64'(tbl[vc].exp_r));
                check("gap_im", 64'(data_out_i), 64'(tbl[vc].exp_i));
                last = i;
                vc++;
            end
        end
        check("gap_count", 64'(vc), 64'd32);
        check("gap_contig", 64'(last - first + 1), 64'd32);

        // Mid-frame reset discards the partial frame.
        for (int n = 0; n < 20; n++) step(1'b0, 1'b1, DW'(n + 100), DW'(n));
        step(1'b1, 1'b0, '0, '0);
        vc = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, '0, '0);
            if (valid_o) vc++;
        end
        check("midrst_no_valid", 64'(vc), 64'd0);
        table_frame();

        // Randomised traffic against the model, with rare resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
                 DW'($urandom), DW'($urandom));
        end
        idle(40);
        check("model_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_output_reorder.md
FFT_OUTPUT_REORDER -- requirements
Module: fft_output_reorder

Interface
REQ-001 Parameter: DATA_W, 19, width of each real/imag component.
REQ-002 Parameter: N, 32, points per frame; LOG2N = 5.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  data_in_r/data_in_i hold one FFT output sample this cycle.
REQ-006 data_in_r  input  DATA_W  real part, two's complement, in bit-reversed order.
REQ-007 data_in_i  input  DATA_W  imaginary part, two's complement.
REQ-008 valid_o  output  1  data_out_r/data_out_i hold one natural-order bin.
REQ-009 data_out_r  output  DATA_W  real part of the current bin, registered.
REQ-010 data_out_i  output  DATA_W  imaginary part of the current bin, registered.

Function
REQ-011 The block SHALL receive the bit-reversed FFT output stream and emit each 32-sample frame in natural bin order.
REQ-012 The write counter n (0..31) SHALL advance only on edges where valid_i=1; sample n SHALL be stored at address bitrev5(n) of the current write bank.
REQ-013 Storage SHALL be ping-pong: two 32x(2*DATA_W) banks; the edge that stores n=31 (edge E) SHALL swap the write bank and arm readout of the filled bank.
REQ-014 Readout SHALL load bin k (address k) into the output registers at edge E+1+k, k=0..31, with valid_o=1 for exactly those 32 contiguous cycles.
REQ-015 Latency: first bin valid in the cycle after edge E+1 (2 edges after the last input sample).
REQ-016 Gaps in valid_i mid-frame SHALL hold the write counter and SHALL NOT create gaps in output of an armed frame.
REQ-017 If the next frame completes at edge E+32 exactly, readout SHALL continue seamlessly: valid_o stays 1, bin 0 of the new frame loads at E+33.
REQ-018 Continuous input at one sample per cycle SHALL never overwrite an unread bank; no backpressure port exists.
REQ-019 When valid_o=0, data_out_r and data_out_i SHALL be 0.
REQ-020 Write counter and read counter SHALL wrap 31->0 with no extra cycle.
REQ-021 Data SHALL pass bit-exact; no scaling, rounding or saturation.

Reset
REQ-022 While rst=1 at an edge: write counter, read counter, bank select, readout-armed flag, valid_o, data_out_r, data_out_i SHALL all become 0.
REQ-023 Reset mid-frame SHALL discard the partial input frame and any frame in readout; bank contents need not be cleared.
REQ-024 The first valid_i sample after reset release SHALL be treated as n=0.

Configuration
REQ-025 Macro FFT_REORDER_INDEX_EN defined: extra output index_o (LOG2N bits) SHALL carry bin k, registered alongside data, 0 when valid_o=0.
REQ-026 Macro undefined: port index_o and its register SHALL not exist; all other behaviour identical.

Structure
REQ-027 Package fft_pkg SHALL hold DATA_W, N, LOG2N, the complex-sample typedef (real, imag) and the bitrev5 function, shared with the FFT stages.
REQ-028 Sub-module fft_reorder_bank (32-entry register file, one write port, one asynchronous read port) SHALL be instantiated twice.

Verification
REQ-029 Reset: hold rst=1 for 3 cycles with random valid_i/data -> valid_o=0, data_out_r=data_out_i=0 throughout and after release until a frame completes.
REQ-030 Single frame: 32 consecutive samples data_in_r=n, data_in_i=-n -> 32 contiguous outputs from 2 edges after last input, data_out_r = 0,16,8,24,4,20,... (bitrev5(k)), data_out_i = -bitrev5(k).
REQ-031 Back-to-back: 64 continuous samples data_in_r=n -> 64 contiguous valid_o cycles; second frame data_out_r = 32+bitrev5(k).
REQ-032 Gapped input: valid_i toggling 1/0 for 64 cycles, data n -> output identical to REQ-030, still 32 contiguous cycles.
REQ-033 Mid-frame reset: rst pulse after 20 samples -> no valid_o; next full 32-sample frame reproduces REQ-030 exactly.
REQ-034 With FFT_REORDER_INDEX_EN: REQ-030 stimulus -> index_o = 0..31 aligned with valid_o, 0 otherwise.
